axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Arbitrates AXI-lite style read channels from two masters, IFU (instruction fetch) and LSU (loads), onto the single read port of the shared SRAM slave.
- Sits between ifu/lsu and the sram read port in the core top. The write channel bypasses this block.
- Keeps one read outstanding at a time, alternates grants round-robin, and bounds the data phase with a timeout that returns an error response and drains any late slave beat.

Parameters:
- DATA_LEN, 32, address and data width.
- TIMEOUT, 255, maximum cycles in the data phase before error termination (1..2^TO_W-1).
- TO_W, 8, timeout counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ifu_arvalid  in  1  IFU read address valid
- ifu_arready  out  1  IFU read address accepted
- ifu_raddr  in  DATA_LEN  IFU read address
- ifu_rvalid  out  1  IFU read data valid
- ifu_rready  in  1  IFU ready for read data
- ifu_rresp  out  3  IFU read response
- ifu_rdata  out  DATA_LEN  IFU read data
- lsu_arvalid / lsu_arready / lsu_raddr / lsu_rvalid / lsu_rready / lsu_rresp / lsu_rdata: same directions, widths and meanings as the ifu_* group, for the LSU
- sram_arvalid  out  1  slave address valid
- sram_arready  in  1  slave address accepted
- sram_raddr  out  DATA_LEN  slave address
- sram_rvalid  in  1  slave data valid
- sram_rready  out  1  slave data ready
- sram_rresp  in  3  slave response
- sram_rdata  in  DATA_LEN  slave data

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low. Reset places the FSM in IDLE, sets the last-grant pointer to LSU (so IFU wins the first tie) and clears the counter.
- Outputs are pure decodes of state and owner. During and after reset, every valid/ready output is 0, every rdata output is 0 and every rresp output is 3'b000.
- Response codes: 3'b000 OKAY (passed through from the slave). 3'b011 is the timeout error, generated by this block.
- FSM states: IDLE, ADDR, DATA, TOERR, DRAIN. Registers: owner (0=IFU, 1=LSU), last, cnt[TO_W-1:0].
- IDLE:
  - If any arvalid is seen in cycle N, the arbiter latches owner: the sole requester, or on a tie the master other than last.
  - It then enters ADDR at N+1. In IDLE no arready is given to either master.
- ADDR:
  - sram_arvalid is the owner's arvalid, sram_raddr is the owner's raddr, and the owner's arready is sram_arready. The non-owner sees arready=0.
  - On arvalid&&arready: go to DATA, last<=owner, cnt<=0.
  - If the owner drops arvalid before the handshake (a protocol violation), return to IDLE with no transfer.
- DATA:
  - sram_rready is the owner's rready. The owner's rvalid, rresp and rdata follow the slave. The non-owner's rvalid is 0.
  - cnt increments every cycle that sram_rvalid is 0.
  - On sram_rvalid&&sram_rready: go to IDLE. Minimum path from request to data is 3 cycles: IDLE, ADDR, DATA.
  - If cnt==TIMEOUT and sram_rvalid==0: go to TOERR.
  - A slave beat arriving in the same cycle as expiry wins; the beat is delivered normally.
- TOERR:
  - The owner sees rvalid=1, rresp=3'b011 and rdata=0. sram_rready is 0.
  - On the owner's rready: go to DRAIN.
- DRAIN:
  - sram_rready is 1 and the slave beat is discarded. No master rvalid is asserted.
  - On sram_rvalid: go to IDLE.
  - There is no timeout in DRAIN; the slave is required to eventually respond.
- Fairness: grants alternate whenever both masters hold requests. No master waits more than one other transaction.
- Back-to-back requests: a master holding arvalid across a completion re-enters arbitration in IDLE. There is always at least 1 idle cycle between transactions.
- Reset mid-transaction: return to IDLE immediately and drop any beat in flight. The slave is reset by the same rst_n.

Decomposition:
- Shared package holds:
  - RESP_OKAY=3'b000 and RESP_TOERR=3'b011.
  - The state encoding: localparams S_IDLE=0, S_ADDR=1, S_DATA=2, S_TOERR=3, S_DRAIN=4 (3 bits).
  - Owner encoding: OWN_IFU=0, OWN_LSU=1.
- One natural sub-module, rr_arb2: a 2-way round-robin picker with a last-grant register and a grant-enable input. Everything else stays flat.

Test Plan:
- IFU alone: ifu_raddr=0x80000000, slave answers 0x00000413 one cycle after arready. Expect ifu_rdata=0x00000413, rresp=0, and lsu_rvalid never asserted.
- Simultaneous arvalid from both masters out of reset: IFU is granted first, then LSU. With both held for 4 transactions, the grant order is IFU,LSU,IFU,LSU.
- Backpressure: slave arready is delayed 3 cycles and the owner's rready is held low 2 cycles. Expect raddr stable and rvalid/rdata held until the handshake, with no duplicate beat.
- Timeout: TIMEOUT=4 and the slave stays silent. Expect owner rvalid=1 with rresp=3'b011 and rdata=0 after 5 data cycles. A late slave beat 0xDEADBEEF is drained, and the next transaction returns correct data.
- Expiry collision: the slave beat lands exactly when cnt==TIMEOUT. Expect the beat delivered with rresp=0 and no TOERR.
- Reset in DATA with LSU owning: assert rst_n=0 for 1 cycle. All valid/ready outputs are 0 immediately. After release, an IFU-only request completes normally.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings for the two-master AXI-lite read arbiter.
package axi_rd_arbiter_pkg;

    localparam int RESP_W = 3;

    localparam logic [RESP_W-1:0] RESP_OKAY  = 3'b000;
    localparam logic [RESP_W-1:0] RESP_TOERR = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_TOERR = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI-lite read channel bundle (address + data phases) shared by IFU, LSU and SRAM.
interface axi_rd_arbiter_if
    import axi_rd_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32
);
    logic                arvalid;
    logic                arready;
    logic [DATA_LEN-1:0] raddr;
    logic                rvalid;
    logic                rready;
    logic [RESP_W-1:0]   rresp;
    logic [DATA_LEN-1:0] rdata;

    // Side that issues reads
    modport master (
        output arvalid, raddr, rready,
        input  arready, rvalid, rresp, rdata
    );

    // Side that services reads
    modport slave (
        input  arvalid, raddr, rready,
        output arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker: remembers the last granted master and favours
// the other one when both request.
module axi_rd_arbiter_rr_arb2
    import axi_rd_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_ifu,
    input  logic i_req_lsu,
    input  logic i_gnt_en,
    input  logic i_gnt_own,
    output logic o_pick,
    output logic o_any
);
    logic r_last;

    // Last-grant pointer; starts at LSU so IFU wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= OWN_LSU;
        end else if (i_gnt_en) begin
            r_last <= i_gnt_own;
        end
    end

    // Sole requester wins; on a tie the master not granted last wins
    always_comb begin
        o_any = i_req_ifu | i_req_lsu;
        if (i_req_ifu && i_req_lsu) begin
            o_pick = ~r_last;
        end else if (i_req_lsu) begin
            o_pick = OWN_LSU;
        end else begin
            o_pick = OWN_IFU;
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Single-outstanding read arbiter between IFU/LSU and the shared SRAM read
// port, with a data-phase timeout that answers with an error and then drains
// the late slave beat.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_rd_arbiter_if.slave  ifu,
    axi_rd_arbiter_if.slave  lsu,
    axi_rd_arbiter_if.master sram
);
    localparam logic [TO_W-1:0] CNT_MAX = TO_W'(TIMEOUT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                w_owner_nxt;
    logic [TO_W-1:0]     r_cnt;
    logic [TO_W-1:0]     w_cnt_nxt;
    logic                w_pick;
    logic                w_any;
    logic                w_gnt_en;
    logic                w_own_arvalid;
    logic                w_own_rready;
    logic [DATA_LEN-1:0] w_own_raddr;

    assign w_own_arvalid = (r_owner == OWN_LSU) ? lsu.arvalid : ifu.arvalid;
    assign w_own_rready  = (r_owner == OWN_LSU) ? lsu.rready  : ifu.rready;
    assign w_own_raddr   = (r_owner == OWN_LSU) ? lsu.raddr   : ifu.raddr;
    assign w_gnt_en      = (r_state == S_ADDR) && w_own_arvalid && sram.arready;

    axi_rd_arbiter_rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req_ifu (ifu.arvalid),
        .i_req_lsu (lsu.arvalid),
        .i_gnt_en  (w_gnt_en),
        .i_gnt_own (r_owner),
        .o_pick    (w_pick),
        .o_any     (w_any)
    );

    // State, owner and data-phase counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= OWN_IFU;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; a beat arriving on the expiry cycle takes priority over the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_gnt_en) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end else if (!w_own_arvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (sram.rvalid) begin
                    if (w_own_rready) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = S_TOERR;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            S_TOERR: begin
                if (w_own_rready) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (sram.rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs decoded from state and owner; non-owner always sees idle values
    always_comb begin
        ifu.arready  = 1'b0;
        ifu.rvalid   = 1'b0;
        ifu.rresp    = RESP_OKAY;
        ifu.rdata    = '0;
        lsu.arready  = 1'b0;
        lsu.rvalid   = 1'b0;
        lsu.rresp    = RESP_OKAY;
        lsu.rdata    = '0;
        sram.arvalid = 1'b0;
        sram.raddr   = '0;
        sram.rready  = 1'b0;
        case (r_state)
            S_ADDR: begin
                sram.arvalid = w_own_arvalid;
                sram.raddr   = w_own_raddr;
                if (r_owner == OWN_LSU) lsu.arready = sram.arready;
                else                    ifu.arready = sram.arready;
            end
            S_DATA: begin
                sram.rready = w_own_rready;
                if (r_owner == OWN_LSU) begin
                    lsu.rvalid = sram.rvalid;
                    lsu.rresp  = sram.rresp;
                    lsu.rdata  = sram.rdata;
                end else begin
                    ifu.rvalid = sram.rvalid;
                    ifu.rresp  = sram.rresp;
                    ifu.rdata  = sram.rdata;
                end
            end
            S_TOERR: begin
                if (r_owner == OWN_LSU) begin
                    lsu.rvalid = 1'b1;
                    lsu.rresp  = RESP_TOERR;
                end else begin
                    ifu.rvalid = 1'b1;
                    ifu.rresp  = RESP_TOERR;
                end
            end
            S_DRAIN: begin
                sram.rready = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_axi_rd_arbiter;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;

    logic clk;
    logic rst_n;

    axi_rd_arbiter_if #(.DATA_LEN(DW)) ifu_if ();
    axi_rd_arbiter_if #(.DATA_LEN(DW)) lsu_if ();
    axi_rd_arbiter_if #(.DATA_LEN(DW)) sram_if ();

    axi_rd_arbiter #(
        .DATA_LEN (DW),
        .TIMEOUT  (TIMEOUT),
        .TO_W     (TO_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifu   (ifu_if),
        .lsu   (lsu_if),
        .sram  (sram_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_last   = 1'b1;   // model: last granted master, 1 = LSU

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid_ready"}, {ifu_if.arready, ifu_if.rvalid, lsu_if.arready, lsu_if.rvalid,
                                    sram_if.arvalid, sram_if.rready}, 32'h0);
        chk({tag, "_ifu_rdata"}, ifu_if.rdata, 32'h0);
        chk({tag, "_lsu_rdata"}, lsu_if.rdata, 32'h0);
        chk({tag, "_rresp"}, {ifu_if.rresp, lsu_if.rresp}, 32'h0);
        chk({tag, "_sram_raddr"}, sram_if.raddr, 32'h0);
    endtask

    task automatic set_rready(input bit own, input logic v);
        if (own) lsu_if.rready = v;
        else     ifu_if.rready = v;
    endtask

    // One full transaction. The model decides owner from the round-robin rule,
    // and a timeout whenever the slave stays silent for more than TIMEOUT data cycles.
    task automatic run_txn(input bit rq_i, input bit rq_l,
                           input logic [31:0] a_i, input logic [31:0] a_l,
                           input logic [31:0] dat, input int ar_dly,
                           input int r_dly, input int rr_dly, input int late_dly);
        bit          own;
        bit          to;
        int          k_end;
        logic [31:0] a_own;
        own   = (rq_i && rq_l) ? ~m_last : rq_l;
        to    = (r_dly > TIMEOUT);
        a_own = own ? a_l : a_i;

        // arbitration cycle: nothing granted yet
        @(negedge clk);
        ifu_if.arvalid = rq_i; ifu_if.raddr = a_i;
        lsu_if.arvalid = rq_l; lsu_if.raddr = a_l;
        ifu_if.rready = 1'b0; lsu_if.rready = 1'b0;
        sram_if.arready = 1'b0; sram_if.rvalid = 1'b0;
        sram_if.rdata = $urandom; sram_if.rresp = 3'b000;
        #1;
        chk("idle_arready", {ifu_if.arready, lsu_if.arready}, 32'h0);
        chk("idle_sram_arvalid", sram_if.arvalid, 32'h0);
        chk("idle_rvalid", {ifu_if.rvalid, lsu_if.rvalid}, 32'h0);

        // address phase, slave arready delayed ar_dly cycles
        for (int i = 0; i <= ar_dly; i++) begin
            @(negedge clk);
            sram_if.arready = (i == ar_dly);
            #1;
            chk("addr_sram_arvalid", sram_if.arvalid, 32'h1);
            chk("addr_raddr", sram_if.raddr, a_own);
            chk("addr_own_arready", own ? lsu_if.arready : ifu_if.arready, (i == ar_dly));
            chk("addr_other_arready", own ? ifu_if.arready : lsu_if.arready, 32'h0);
        end
        m_last = own;

        // data phase
        k_end = to ? TIMEOUT : (r_dly + rr_dly);
        for (int k = 0; k <= k_end; k++) begin
            logic v;
            logic rr;
            v  = !to && (k >= r_dly);
            rr = !to && (k >= r_dly + rr_dly);
            @(negedge clk);
            sram_if.arready = 1'b0;
            if (own) lsu_if.arvalid = 1'b0;
            else     ifu_if.arvalid = 1'b0;
            sram_if.rvalid = v;
            sram_if.rdata  = v ? dat : $urandom;
            set_rready(own, rr);
            #1;
            chk("data_other_rvalid", own ? ifu_if.rvalid : lsu_if.rvalid, 32'h0);
            chk("data_own_rvalid", own ? lsu_if.rvalid : ifu_if.rvalid, v);
            chk("data_sram_rready", sram_if.rready, rr);
            if (v) begin
                chk("data_rdata", own ? lsu_if.rdata : ifu_if.rdata, dat);
                chk("data_rresp", own ? lsu_if.rresp : ifu_if.rresp, 32'h0);
            end
        end

        if (to) begin
            // error response held until the owner accepts it
            for (int j = 0; j <= rr_dly; j++) begin
                @(negedge clk);
                sram_if.rvalid = 1'b0;
                sram_if.rdata  = $urandom;
                set_rready(own, (j == rr_dly));
                #1;
                chk("toerr_rvalid", own ? lsu_if.rvalid : ifu_if.rvalid, 32'h1);
                chk("toerr_rresp", own ? lsu_if.rresp : ifu_if.rresp, 32'h3);
                chk("toerr_rdata", own ? lsu_if.rdata : ifu_if.rdata, 32'h0);
                chk("toerr_other_rvalid", own ? ifu_if.rvalid : lsu_if.rvalid, 32'h0);
                chk("toerr_sram_rready", sram_if.rready, 32'h0);
            end
            // late beat swallowed
            for (int j = 0; j <= late_dly; j++) begin
                @(negedge clk);
                set_rready(own, 1'b1);
                sram_if.rvalid = (j == late_dly);
                sram_if.rdata  = 32'hDEAD_BEEF;
                #1;
                chk("drain_sram_rready", sram_if.rready, 32'h1);
                chk("drain_rvalid", {ifu_if.rvalid, lsu_if.rvalid}, 32'h0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        ifu_if.arvalid = 1'b0; ifu_if.raddr = '0; ifu_if.rready = 1'b0;
        lsu_if.arvalid = 1'b0; lsu_if.raddr = '0; lsu_if.rready = 1'b0;
        sram_if.arready = 1'b0; sram_if.rvalid = 1'b0; sram_if.rresp = '0; sram_if.rdata = '0;
        #2 rst_n = 1'b0;
        #1 chk_quiet("reset");

        // inputs active while reset is held must not leak through
        @(negedge clk);
        ifu_if.arvalid = 1'b1; lsu_if.arvalid = 1'b1; ifu_if.rready = 1'b1;
        sram_if.arready = 1'b1; sram_if.rvalid = 1'b1; sram_if.rdata = 32'hFFFF_FFFF; sram_if.rresp = 3'b111;
        #1 chk_quiet("reset_driven");
        @(negedge clk);
        ifu_if.arvalid = 1'b0; lsu_if.arvalid = 1'b0; ifu_if.rready = 1'b0;
        sram_if.arready = 1'b0; sram_if.rvalid = 1'b0; sram_if.rresp = 3'b000;
        rst_n = 1'b1;

        // both masters held: IFU, LSU, IFU, LSU
        for (int t = 0; t < 4; t++)
            run_txn(1'b1, 1'b1, 32'h1000_0000 + t, 32'h2000_0000 + t, 32'hA5A5_0000 + t, 0, 0, 0, 0);

        // IFU alone, beat one cycle after arready
        run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_0413, 0, 0, 0, 0);

        // backpressure: arready late by 3, owner rready low 2 cycles after the beat
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_3000, 32'h1357_9BDF, 3, 1, 2, 0);

        // timeout with late beat drained, then a clean transfer
        run_txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 0, TIMEOUT + 1, 1, 2);
        run_txn(1'b1, 1'b0, 32'h0000_4004, 32'h0, 32'h0BAD_F00D, 0, 1, 0, 0);

        // beat lands on the expiry cycle
        run_txn(1'b0, 1'b1, 32'h0, 32'h0000_5000, 32'hCAFE_0001, 0, TIMEOUT, 0, 0);
        run_txn(1'b1, 1'b0, 32'h0000_5004, 32'h0, 32'hCAFE_0002, 1, TIMEOUT, 1, 0);

        // reset while LSU owns the data phase
        @(negedge clk);
        ifu_if.arvalid = 1'b0; lsu_if.arvalid = 1'b1; lsu_if.raddr = 32'h0000_6000;
        ifu_if.rready = 1'b0; lsu_if.rready = 1'b0;
        sram_if.arready = 1'b0; sram_if.rvalid = 1'b0;
        @(negedge clk);
        sram_if.arready = 1'b1;
        #1 chk("rstdata_arready", lsu_if.arready, 32'h1);
        @(negedge clk);
        lsu_if.arvalid = 1'b0; sram_if.arready = 1'b0;
        sram_if.rvalid = 1'b1; sram_if.rdata = 32'h1234_5678;
        #1 chk("rstdata_rvalid", lsu_if.rvalid, 32'h1);
        rst_n = 1'b0;
        #1 chk_quiet("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        sram_if.rvalid = 1'b0;
        m_last = 1'b1;
        run_txn(1'b1, 1'b0, 32'h0000_7000, 32'h0, 32'h7777_0001, 0, 0, 0, 0);
        run_txn(1'b1, 1'b1, 32'h0000_7004, 32'h0000_7008, 32'h7777_0002, 0, 2, 1, 0);

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            int r;
            r = $urandom_range(1, 3);
            run_txn(r[0], r[1], $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, TIMEOUT + 2),
                    $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // final quiet cycle
        @(negedge clk);
        ifu_if.arvalid = 1'b0; lsu_if.arvalid = 1'b0;
        ifu_if.rready = 1'b0; lsu_if.rready = 1'b0;
        sram_if.arready = 1'b0; sram_if.rvalid = 1'b0;
        #1 chk_quiet("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
